ps2_mouse_position_regs: RTL

- Bus-mapped mouse position peripheral that sits between the PS/2 mouse master state machine and the processor data bus.
- Converts per-packet signed deltas into clamped absolute X/Y coordinates with programmable sensitivity, optional Y inversion, coherent multi-byte reads, position preset by bus write, and a held interrupt with acknowledge.
- Successor to the fixed-address, delta-only mouse register front end; screen size, coordinate widths and base address are parametrised.

---
 rtl/ps2_mouse_pkg.sv | 34 +++
 rtl/mouse_axis_accumulator.sv | 69 ++++++
 rtl/ps2_mouse_position_regs.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared constants for the PS/2 mouse position peripheral: register offsets,
// STATUS/CTRL bit positions, PS/2 byte-0 bit positions and the CTRL reset value.
// No logic lives here.
package ps2_mouse_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [7:0] OFF_STATUS = 8'd0;
    localparam logic [7:0] OFF_X_LO   = 8'd1;
    localparam logic [7:0] OFF_X_HI   = 8'd2;
    localparam logic [7:0] OFF_Y_LO   = 8'd3;
    localparam logic [7:0] OFF_Y_HI   = 8'd4;
    localparam logic [7:0] OFF_CTRL   = 8'd5;
    localparam logic [7:0] REG_COUNT  = 8'd6;

    // STATUS register bits ([2:0] are the buttons in PS/2 order)
    localparam int ST_EN_BIT  = 3;
    localparam int ST_OVF_BIT = 4;
    localparam int ST_IRQ_BIT = 5;

    // CTRL register bits
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SCALE_LO = 1;
    localparam int CTRL_SCALE_HI = 2;

    // PS/2 packet byte 0 bits
    localparam int PS2_L   = 0;
    localparam int PS2_R   = 1;
    localparam int PS2_M   = 2;
    localparam int PS2_XOV = 6;
    localparam int PS2_YOV = 7;

    localparam logic [7:0] CTRL_RESET = 8'h01;

endpackage

// File: rtl/mouse_axis_accumulator.sv
// One coordinate axis: position register, staging byte for bus presets, scaled
// signed delta accumulation with clamping to [0, MAX]; a bus HI commit overrides
// a simultaneous delta. Ports: clk/rst, apply+delta+scale (packet side),
// lo_wr/hi_wr/wdat (bus side), pos (live position).
module mouse_axis_accumulator #(
    parameter int WIDTH  = 10,
    parameter int MAX    = 639,
    parameter int INIT   = 320,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apply,
    input  logic [8:0]       delta,
    input  logic [1:0]       scale,
    input  logic             lo_wr,
    input  logic             hi_wr,
    input  logic [7:0]       wdat,
    output logic [WIDTH-1:0] pos
);

    // Wide enough that pos +/- (255 << 3) can never wrap
    localparam int SW = WIDTH + 12;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

    logic              [7:0]    stage;
    logic signed       [SW-1:0] pos_s;
    logic signed       [SW-1:0] delta_s;
    logic signed       [SW-1:0] shifted;
    logic signed       [SW-1:0] sum;
    logic              [WIDTH-1:0] acc_pos;
    logic              [15:0]   commit_val;
    logic              [WIDTH-1:0] commit_pos;

    always_comb begin
        pos_s   = {{(SW-WIDTH){1'b0}}, pos};
        delta_s = {{(SW-9){delta[8]}}, delta};
        shifted = delta_s <<< scale;
        sum     = INVERT ? (pos_s - shifted) : (pos_s + shifted);
        if (sum < 0)
            acc_pos = '0;
        else if (sum > MAX_S)
            acc_pos = WIDTH'(MAX);
        else
            acc_pos = sum[WIDTH-1:0];

        commit_val = {wdat, stage};
        if (commit_val > 16'(MAX))
            commit_pos = WIDTH'(MAX);
        else
            commit_pos = commit_val[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos   <= WIDTH'(INIT);
            stage <= '0;
        end else begin
            if (lo_wr)
                stage <= wdat;
            // Bus preset beats a packet delta landing on the same edge
            if (hi_wr)
                pos <= commit_pos;
            else if (apply)
                pos <= acc_pos;
        end
    end

endmodule

// File: rtl/ps2_mouse_position_regs.sv
// Bus-mapped mouse position peripheral: PS/2 packets in, clamped X/Y, buttons,
// STATUS/CTRL registers, coherent X/Y snapshot reads and a held interrupt.
// Ports: CLK/RESET, PKT_* (packet strobe+fields), BUS_* (6-byte register window,
// read data driven the cycle after the address), INTERRUPT_ACK/RAISE, LEFT/RIGHT/
// MIDDLE, POS_X/POS_Y.
module ps2_mouse_position_regs
    import ps2_mouse_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         X_WIDTH   = 10,
    parameter int         Y_WIDTH   = 10,
    parameter int         X_MAX     = 639,
    parameter int         Y_MAX     = 479,
    parameter int         X_INIT    = 320,
    parameter int         Y_INIT    = 240,
    parameter bit         INVERT_Y  = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PKT_VALID,
    input  logic [7:0]         PKT_STATUS,
    input  logic [8:0]         PKT_DX,
    input  logic [8:0]         PKT_DY,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    inout  wire  [7:0]         BUS_DATA,
    input  logic               INTERRUPT_ACK,
    output logic               INTERRUPT_RAISE,
    output logic               LEFT,
    output logic               RIGHT,
    output logic               MIDDLE,
    output logic [X_WIDTH-1:0] POS_X,
    output logic [Y_WIDTH-1:0] POS_Y
);

    logic [7:0]         offset;
    logic               sel;
    logic               rd;
    logic               wr;
    logic [2:0]         ctrl;
    logic               en;
    logic [1:0]         scale;
    logic               pkt_acc;
    logic               ovf;
    logic               ovf_set;
    logic [X_WIDTH-1:0] snap_x;
    logic [Y_WIDTH-1:0] snap_y;
    logic [15:0]        snap_x16;
    logic [15:0]        snap_y16;
    logic [15:0]        live_x16;
    logic [7:0]         rd_byte;
    logic [7:0]         rd_dat;
    logic               rd_vld;
    logic [7:0]         wdat;

    // Subtracting the base keeps decode correct even if the window wraps 8'hFF
    assign offset  = BUS_ADDR - BASE_ADDR;
    assign sel     = offset < REG_COUNT;
    assign rd      = sel & ~BUS_WE;
    assign wr      = sel & BUS_WE;
    assign wdat    = BUS_DATA;

    assign en      = ctrl[CTRL_EN_BIT];
    assign scale   = ctrl[CTRL_SCALE_HI:CTRL_SCALE_LO];
    assign pkt_acc = PKT_VALID & en;
    assign ovf_set = pkt_acc & (PKT_STATUS[PS2_XOV] | PKT_STATUS[PS2_YOV]);

    mouse_axis_accumulator #(
        .WIDTH (X_WIDTH),
        .MAX   (X_MAX),
        .INIT  (X_INIT),
        .INVERT(1'b0)
    ) u_x (
        .clk  (CLK),
        .rst  (RESET),
        .apply(pkt_acc & ~PKT_STATUS[PS2_XOV]),
        .delta(PKT_DX),
        .scale(scale),
        .lo_wr(wr && offset == OFF_X_LO),
        .hi_wr(wr && offset == OFF_X_HI),
        .wdat (wdat),
        .pos  (POS_X)
    );

    mouse_axis_accumulator #(
        .WIDTH (Y_WIDTH),
        .MAX   (Y_MAX),
        .INIT  (Y_INIT),
        .INVERT(INVERT_Y)
    ) u_y (
        .clk  (CLK),
        .rst  (RESET),
        .apply(pkt_acc & ~PKT_STATUS[PS2_YOV]),
        .delta(PKT_DY),
        .scale(scale),
        .lo_wr(wr && offset == OFF_Y_LO),
        .hi_wr(wr && offset == OFF_Y_HI),
        .wdat (wdat),
        .pos  (POS_Y)
    );

    // Read byte is formed from pre-edge state and registered, so a STATUS read
    // returns the overflow flag as it was before the read clears it. An X_LO
    // read returns live X, which is exactly what the snapshot captures.
    always_comb begin
        snap_x16 = 16'(snap_x);
        snap_y16 = 16'(snap_y);
        live_x16 = 16'(POS_X);
        rd_byte  = '0;
        case (offset)
            OFF_STATUS: begin
                rd_byte[PS2_L]      = LEFT;
                rd_byte[PS2_R]      = RIGHT;
                rd_byte[PS2_M]      = MIDDLE;
                rd_byte[ST_EN_BIT]  = en;
                rd_byte[ST_OVF_BIT] = ovf;
                rd_byte[ST_IRQ_BIT] = INTERRUPT_RAISE;
            end
            OFF_X_LO: rd_byte = live_x16[7:0];
            OFF_X_HI: rd_byte = snap_x16[15:8];
            OFF_Y_LO: rd_byte = snap_y16[7:0];
            OFF_Y_HI: rd_byte = snap_y16[15:8];
            OFF_CTRL: rd_byte = {5'b0, ctrl};
            default:  rd_byte = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl            <= CTRL_RESET[2:0];
            LEFT            <= 1'b0;
            RIGHT           <= 1'b0;
            MIDDLE          <= 1'b0;
            INTERRUPT_RAISE <= 1'b0;
            ovf             <= 1'b0;
            snap_x          <= X_WIDTH'(X_INIT);
            snap_y          <= Y_WIDTH'(Y_INIT);
            rd_vld          <= 1'b0;
            rd_dat          <= '0;
        end else begin
            rd_vld <= rd;
            if (rd)
                rd_dat <= rd_byte;
            if (rd && offset == OFF_X_LO) begin
                snap_x <= POS_X;
                snap_y <= POS_Y;
            end

            // Packet on this edge sees the old CTRL
            if (wr && offset == OFF_CTRL)
                ctrl <= wdat[2:0];

            if (PKT_VALID) begin
                LEFT   <= PKT_STATUS[PS2_L];
                RIGHT  <= PKT_STATUS[PS2_R];
                MIDDLE <= PKT_STATUS[PS2_M];
            end

            // A new overflow wins over a clearing STATUS read on the same edge
            if (ovf_set)
                ovf <= 1'b1;
            else if (rd && offset == OFF_STATUS)
                ovf <= 1'b0;

            // A new packet wins over an acknowledge on the same edge
            if (pkt_acc)
                INTERRUPT_RAISE <= 1'b1;
            else if (INTERRUPT_ACK)
                INTERRUPT_RAISE <= 1'b0;
        end
    end

    assign BUS_DATA = rd_vld ? rd_dat : 8'bz;

endmodule
